spi_rx_deserializer: RTL and testbench
======================================

// Module: spi_rx_deserializer
// PURPOSE
//  Receive path for the SPI master, downstream of the spi_rx pin. It samples spi_rx on the
//  mode-correct edge of the generated spi_clk and assembles MSB-first words of WORD_SIZE+1 bits.
//  Finished words go into an RX FIFO whose head is read through the DATA register.
//  Drives the RXFE/RXFF/RXFO bits of the STATUS register. Runs entirely in the clk domain;
//  spi_clk is a clk-synchronous divider output.
// PARAMETERS
//  DEPTH   16  RX FIFO entries; power of two
//  ADDR_W  4   log2(DEPTH); pointer width
// PORTS
//  clk          in   1   system clock (50 MHz); all logic on posedge clk
//  reset_n      in   1   asynchronous, active-low reset
//  spi_clk      in   1   SPI clock from the baud divider, already idling at CPOL
//  spi_rx       in   1   MISO pin
//  cpol         in   1   polarity of the selected device (MODEn[1])
//  cpha         in   1   phase of the selected device (MODEn[0])
//  word_size    in   5   bits per word minus 1 (control[4:0]); 0..31 = 1..32 bits
//  frame_active in   1   high while the serializer is in TX_RX
//  pop          in   1   one-clk pulse: Avalon read of DATA reg, removes the head
//  clear_ov     in   1   one-clk pulse: W1C of the RXFO status bit
//  rx_data      out  32  head word, zero-extended above word_size; 0 when empty
//  rxfe         out  1   FIFO empty
//  rxff         out  1   FIFO full
//  rxfo         out  1   sticky overflow
//  rx_level     out  5   number of entries, 0..DEPTH
//  word_done    out  1   one-clk pulse when a word completes (pushed or dropped)
// BEHAVIOUR
//  Reset (async assert; release synchronous to clk):
//   - Pointers, level, shift register, bit counter, sclk_d = cpol, rxfo and word_done all go to 0.
//   - rxfe=1, rxff=0, rx_data=0.
//   - FIFO memory contents are don't-care.
//  Edge detect:
//   - sclk_d <= spi_clk every clk; rise = spi_clk & ~sclk_d; fall = ~spi_clk & sclk_d.
//   - Sample edge is rise when cpol==cpha, fall otherwise (modes 0 and 3 sample on rise).
//  States:
//   - IDLE: bit counter loaded with word_size and shift register cleared.
//     On frame_active=1 -> SHIFT, latching word_size into wsz_q.
//   - SHIFT: on each sample edge, shreg <= {shreg[30:0], spi_rx} and cnt decrements.
//     When a sample is taken with cnt==0 -> PUSH.
//     frame_active falling mid-word -> IDLE; the partial word is discarded with no push and no flag.
//   - PUSH (1 clk): word_done=1.
//     If FIFO not full, or pop is asserted in the same clk: write shreg masked to wsz_q+1 bits.
//     Otherwise drop the word and set rxfo=1.
//     Then -> SHIFT if frame_active, else -> IDLE. cnt is reloaded from wsz_q.
//  FIFO:
//   - Write at wr_ptr, read at rd_ptr; pointers wrap modulo DEPTH.
//   - rx_level tracks push/pop; push and pop in the same clk leaves rx_level unchanged.
//   - rxfe = (rx_level==0); rxff = (rx_level==DEPTH).
//   - Pop when empty is ignored: pointers and level hold, rx_data stays 0.
//   - rx_data is show-ahead (mem[rd_ptr], 0 if empty).
//     After pop, rx_data shows the next entry on the following clk.
//   - Push into an empty FIFO makes rx_data valid one clk after PUSH.
//  Overflow:
//   - rxfo stays 1 until clear_ov.
//   - If clear_ov and a new overflow happen in the same clk, set wins (rxfo stays 1).
//   - Dropped words never corrupt stored entries.
//  Latency:
//   - Last sample edge, then 1 clk to PUSH, then 1 clk until rxfe=0 and rx_data valid.
//  Changes to cpol/cpha/word_size while in SHIFT are ignored until the next IDLE.
// TESTING
//  T1 mode 0, word_size=7, shift in 0xA5 -> word_done pulse, rx_data=0x000000A5, rxfe=0, rx_level=1.
//  T2 mode 3, word_size=31, shift 0xDEADBEEF; then pop -> rx_data=0xDEADBEEF; after pop rxfe=1, rx_data=0.
//  T3 mode 1 and mode 2, word_size=3, shift 4'b1001 -> rx_data=0x9; sampling on the falling edge is confirmed.
//  T4 17 words 0x00..0x10 without pop -> rxff=1, rxfo=1, 16 pops return 0x00..0x0F; clear_ov -> rxfo=0.
//  T5 FIFO full, pop coincides with PUSH -> word stored, rxfo stays 0, rx_level stays 16; pop on empty -> no change.
//  T6 frame_active drops after 3 of 8 bits -> no push; reset_n low mid-frame -> all outputs reset, rxfe=1.

Source files
------------

// File: rtl/spi_rx_deserializer.sv
// ----------------------------------------------------------------------------
// spi_rx_deserializer
// Receive half of the SPI master. Samples the MISO pin on the mode-correct edge
// of the clk-synchronous spi_clk, assembles MSB-first words of word_size+1 bits
// and queues finished words in a show-ahead RX FIFO. It also produces the
// RXFE/RXFF/RXFO status bits. Everything runs in the clk domain.
// ----------------------------------------------------------------------------
module spi_rx_deserializer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_clk,
    input  logic              spi_rx,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [4:0]        word_size,
    input  logic              frame_active,
    input  logic              pop,
    input  logic              clear_ov,
    output logic [31:0]       rx_data,
    output logic              rxfe,
    output logic              rxff,
    output logic              rxfo,
    output logic [ADDR_W:0]   rx_level,
    output logic              word_done
);

    // Receive sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PUSH  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   LVL_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] PTR_ONE  = (ADDR_W)'(1);

    // Mask keeping the low wsz+1 bits of a word; wsz=31 keeps all 32 bits.
    function automatic logic [31:0] width_mask(input logic [4:0] wsz);
        logic [32:0] m;
        m = (33'h0_0000_0001 << ({1'b0, wsz} + 6'd1)) - 33'h0_0000_0001;
        return m[31:0];
    endfunction

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_sclk_d;
    logic                w_rise;
    logic                w_fall;
    logic                w_sample;

    logic                r_cpol_q;
    logic                r_cpha_q;
    logic [4:0]          r_wsz_q;
    logic [4:0]          r_cnt;
    logic [31:0]         r_shreg;

    logic                w_load_cfg;
    logic                w_shift;
    logic                w_is_push;

    logic [31:0]         r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_level;
    logic [31:0]         r_rx_data;
    logic                r_rxfe;
    logic                r_rxff;
    logic                r_rxfo;
    logic                r_word_done;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_drop;
    logic [31:0]         w_wdata;
    logic [ADDR_W-1:0]   w_rd_nxt;
    logic [ADDR_W:0]     w_level_nxt;
    logic [31:0]         w_head_nxt;

    // ------------------------------------------------------------------
    // spi_clk edge detection
    // ------------------------------------------------------------------

    // Delay spi_clk by one clk so its edges can be seen as single-clk pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_d <= cpol;
        end else begin
            r_sclk_d <= spi_clk;
        end
    end

    assign w_rise = spi_clk & ~r_sclk_d;
    assign w_fall = ~spi_clk & r_sclk_d;

    // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling one;
    // the mode latched at frame start is used so mid-frame changes are ignored.
    always_comb begin
        w_sample = 1'b0;
        if (r_cpol_q == r_cpha_q) begin
            w_sample = w_rise;
        end else begin
            w_sample = w_fall;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------

    // State register of the receive sequencer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the strobes that steer the shift datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_load_cfg  = 1'b0;
        w_shift     = 1'b0;
        w_is_push   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (frame_active) begin
                    w_state_nxt = ST_SHIFT;
                    w_load_cfg  = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!frame_active) begin
                    // Frame aborted mid-word: partial word is silently dropped.
                    w_state_nxt = ST_IDLE;
                end else if (w_sample) begin
                    w_shift = 1'b1;
                    if (r_cnt == 5'd0) begin
                        w_state_nxt = ST_PUSH;
                    end else begin
                        w_state_nxt = ST_SHIFT;
                    end
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_PUSH: begin
                w_is_push = 1'b1;
                if (frame_active) begin
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Shift register, bit counter and the per-frame configuration latch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shreg  <= 32'h0000_0000;
            r_cnt    <= 5'd0;
            r_wsz_q  <= 5'd0;
            r_cpol_q <= 1'b0;
            r_cpha_q <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt   <= word_size;
                    r_shreg <= 32'h0000_0000;
                    if (w_load_cfg) begin
                        r_wsz_q  <= word_size;
                        r_cpol_q <= cpol;
                        r_cpha_q <= cpha;
                    end else begin
                        r_wsz_q  <= r_wsz_q;
                        r_cpol_q <= r_cpol_q;
                        r_cpha_q <= r_cpha_q;
                    end
                end
                ST_SHIFT: begin
                    if (w_shift) begin
                        r_shreg <= {r_shreg[30:0], spi_rx};
                        r_cnt   <= r_cnt - 5'd1;
                    end else begin
                        r_shreg <= r_shreg;
                        r_cnt   <= r_cnt;
                    end
                end
                ST_PUSH: begin
                    r_cnt   <= r_wsz_q;
                    r_shreg <= 32'h0000_0000;
                end
                default: begin
                    r_cnt   <= r_wsz_q;
                    r_shreg <= 32'h0000_0000;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    assign w_full  = (r_level == LVL_FULL);
    assign w_empty = (r_level == LVL_ZERO);
    assign w_pop   = pop & ~w_empty;
    // A full FIFO still accepts the word when the head is popped the same clk.
    assign w_push  = w_is_push & (~w_full | pop);
    assign w_drop  = w_is_push & w_full & ~pop;
    assign w_wdata = r_shreg & width_mask(r_wsz_q);

    // Next level, next read pointer and the head word that becomes visible.
    always_comb begin
        w_level_nxt = r_level;
        w_rd_nxt    = r_rd_ptr;
        w_head_nxt  = 32'h0000_0000;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + LVL_ONE;
            2'b01:   w_level_nxt = r_level - LVL_ONE;
            default: w_level_nxt = r_level;
        endcase
        if (w_pop) begin
            w_rd_nxt = r_rd_ptr + PTR_ONE;
        end else begin
            w_rd_nxt = r_rd_ptr;
        end
        if (w_level_nxt == LVL_ZERO) begin
            w_head_nxt = 32'h0000_0000;
        end else if (w_push && (r_wr_ptr == w_rd_nxt)) begin
            // The word being written becomes the head: bypass the memory.
            w_head_nxt = w_wdata;
        end else begin
            w_head_nxt = r_mem[w_rd_nxt];
        end
    end

    // FIFO storage; contents need no reset because reads are gated by level.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wdata;
        end
    end

    // Pointers, level and the registered head/status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr  <= PTR_ZERO;
            r_rd_ptr  <= PTR_ZERO;
            r_level   <= LVL_ZERO;
            r_rx_data <= 32'h0000_0000;
            r_rxfe    <= 1'b1;
            r_rxff    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            r_rd_ptr  <= w_rd_nxt;
            r_level   <= w_level_nxt;
            r_rx_data <= w_head_nxt;
            r_rxfe    <= (w_level_nxt == LVL_ZERO);
            r_rxff    <= (w_level_nxt == LVL_FULL);
        end
    end

    // Sticky overflow flag; a new overflow beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rxfo <= 1'b0;
        end else if (w_drop) begin
            r_rxfo <= 1'b1;
        end else if (clear_ov) begin
            r_rxfo <= 1'b0;
        end else begin
            r_rxfo <= r_rxfo;
        end
    end

    // Word-complete strobe, high for exactly the clk spent in PUSH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_word_done <= 1'b0;
        end else begin
            r_word_done <= (w_state_nxt == ST_PUSH);
        end
    end

    assign rx_data   = r_rx_data;
    assign rxfe      = r_rxfe;
    assign rxff      = r_rxff;
    assign rxfo      = r_rxfo;
    assign rx_level  = r_level;
    assign word_done = r_word_done;

endmodule

// File: tb/tb_spi_rx_deserializer.sv
// ----------------------------------------------------------------------------
// Self-checking bench for spi_rx_deserializer: a table of single-word
// transfers across all SPI modes, plus hand-written FIFO full/overflow,
// pop-during-push, frame-abort and mid-frame reset sequences.
// ----------------------------------------------------------------------------
module tb_spi_rx_deserializer;

    logic        clk;
    logic        reset_n;
    logic        spi_clk;
    logic        spi_rx;
    logic        cpol;
    logic        cpha;
    logic [4:0]  word_size;
    logic        frame_active;
    logic        pop;
    logic        clear_ov;
    logic [31:0] rx_data;
    logic        rxfe;
    logic        rxff;
    logic        rxfo;
    logic [4:0]  rx_level;
    logic        word_done;

    int tests;
    int fails;
    int done_cnt;
    int done_base;
    int got;

    typedef struct {
        logic        cp;
        logic        ph;
        logic [4:0]  wsz;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];

    spi_rx_deserializer #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .spi_clk      (spi_clk),
        .spi_rx       (spi_rx),
        .cpol         (cpol),
        .cpha         (cpha),
        .word_size    (word_size),
        .frame_active (frame_active),
        .pop          (pop),
        .clear_ov     (clear_ov),
        .rx_data      (rx_data),
        .rxfe         (rxfe),
        .rxff         (rxff),
        .rxfo         (rxfo),
        .rx_level     (rx_level),
        .word_done    (word_done)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Count word_done pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (reset_n && word_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic start_frame(input logic cp, input logic ph, input logic [4:0] wsz);
        cpol = cp;
        cpha = ph;
        word_size = wsz;
        spi_clk = cp;
        spi_rx = 1'b0;
        tick(2);
        frame_active = 1'b1;
        tick(2);
    endtask

    task automatic end_frame();
        frame_active = 1'b0;
        spi_rx = 1'b0;
        tick(2);
    endtask

    // Drive nbits of data MSB first; data changes on the non-sampling edge
    // (one clk late for cpha=1) so sampling on the wrong edge gives wrong bits.
    task automatic send_word(input logic [31:0] data, input int nbits, input logic cp, input logic ph);
        for (int i = nbits - 1; i >= 0; i--) begin
            if (ph == 1'b0) begin
                spi_rx = data[i];
                tick(2);
                spi_clk = ~cp;
                tick(2);
                spi_clk = cp;
            end else begin
                spi_clk = ~cp;
                tick(1);
                spi_rx = data[i];
                tick(2);
                spi_clk = cp;
                tick(2);
            end
        end
        tick(2);
    endtask

    task automatic pop_one();
        pop = 1'b1;
        tick(1);
        pop = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        done_cnt = 0;
        reset_n = 1'b0;
        spi_clk = 1'b0;
        spi_rx = 1'b0;
        cpol = 1'b0;
        cpha = 1'b0;
        word_size = 5'd7;
        frame_active = 1'b0;
        pop = 1'b0;
        clear_ov = 1'b0;

        vecs[0] = '{cp: 1'b0, ph: 1'b0, wsz: 5'd7,  data: 32'h0000_00A5, exp: 32'h0000_00A5};
        vecs[1] = '{cp: 1'b1, ph: 1'b1, wsz: 5'd31, data: 32'hDEAD_BEEF, exp: 32'hDEAD_BEEF};
        vecs[2] = '{cp: 1'b0, ph: 1'b1, wsz: 5'd3,  data: 32'h0000_0009, exp: 32'h0000_0009};
        vecs[3] = '{cp: 1'b1, ph: 1'b0, wsz: 5'd3,  data: 32'h0000_0009, exp: 32'h0000_0009};
        vecs[4] = '{cp: 1'b0, ph: 1'b0, wsz: 5'd0,  data: 32'h0000_0001, exp: 32'h0000_0001};
        vecs[5] = '{cp: 1'b1, ph: 1'b1, wsz: 5'd15, data: 32'h0000_8001, exp: 32'h0000_8001};
        vecs[6] = '{cp: 1'b0, ph: 1'b1, wsz: 5'd31, data: 32'h8000_0001, exp: 32'h8000_0001};

        tick(3);
        chk("reset_rxfe", {31'd0, rxfe}, 32'd1);
        chk("reset_rxff", {31'd0, rxff}, 32'd0);
        chk("reset_rxfo", {31'd0, rxfo}, 32'd0);
        chk("reset_level", {27'd0, rx_level}, 32'd0);
        chk("reset_data", rx_data, 32'd0);
        chk("reset_done", {31'd0, word_done}, 32'd0);
        reset_n = 1'b1;
        tick(2);

        // Table of single words: one transfer, check head, then pop it.
        for (int v = 0; v < 7; v++) begin
            done_base = done_cnt;
            start_frame(vecs[v].cp, vecs[v].ph, vecs[v].wsz);
            send_word(vecs[v].data, int'(vecs[v].wsz) + 1, vecs[v].cp, vecs[v].ph);
            end_frame();
            chk($sformatf("vec%0d_data", v), rx_data, vecs[v].exp);
            chk($sformatf("vec%0d_rxfe", v), {31'd0, rxfe}, 32'd0);
            chk($sformatf("vec%0d_level", v), {27'd0, rx_level}, 32'd1);
            chk($sformatf("vec%0d_done", v), done_cnt - done_base, 32'd1);
            pop_one();
            chk($sformatf("vec%0d_pop_rxfe", v), {31'd0, rxfe}, 32'd1);
            chk($sformatf("vec%0d_pop_data", v), rx_data, 32'd0);
        end

        // Overflow: 17 words into a 16-entry FIFO, then drain and clear.
        done_base = done_cnt;
        start_frame(1'b0, 1'b0, 5'd7);
        for (int w = 0; w < 17; w++) begin
            send_word(w, 8, 1'b0, 1'b0);
            if (w == 15) chk("ov_rxfo_before", {31'd0, rxfo}, 32'd0);
        end
        end_frame();
        chk("ov_done", done_cnt - done_base, 32'd17);
        chk("ov_rxff", {31'd0, rxff}, 32'd1);
        chk("ov_rxfo", {31'd0, rxfo}, 32'd1);
        chk("ov_level", {27'd0, rx_level}, 32'd16);
        for (int w = 0; w < 16; w++) begin
            chk($sformatf("ov_pop%0d", w), rx_data, w);
            pop_one();
        end
        chk("ov_empty_rxfe", {31'd0, rxfe}, 32'd1);
        chk("ov_empty_data", rx_data, 32'd0);
        chk("ov_rxfo_sticky", {31'd0, rxfo}, 32'd1);
        clear_ov = 1'b1;
        tick(1);
        clear_ov = 1'b0;
        chk("ov_cleared", {31'd0, rxfo}, 32'd0);

        // Full FIFO with a pop coinciding with PUSH: word must be kept.
        start_frame(1'b0, 1'b0, 5'd7);
        for (int w = 0; w < 16; w++) send_word(w, 8, 1'b0, 1'b0);
        chk("pp_full", {31'd0, rxff}, 32'd1);
        got = 0;
        fork
            send_word(32'h10, 8, 1'b0, 1'b0);
            begin
                for (int k = 0; k < 400 && got == 0; k++) begin
                    @(negedge clk);
                    if (word_done === 1'b1) begin
                        pop = 1'b1;
                        got = 1;
                        @(negedge clk);
                        pop = 1'b0;
                    end
                end
            end
        join
        end_frame();
        chk("pp_seen_done", got, 32'd1);
        chk("pp_rxfo", {31'd0, rxfo}, 32'd0);
        chk("pp_level", {27'd0, rx_level}, 32'd16);
        chk("pp_rxff", {31'd0, rxff}, 32'd1);
        for (int w = 1; w < 17; w++) begin
            chk($sformatf("pp_pop%0d", w), rx_data, w);
            pop_one();
        end
        chk("pp_drained", {31'd0, rxfe}, 32'd1);
        pop_one();
        tick(1);
        chk("empty_pop_level", {27'd0, rx_level}, 32'd0);
        chk("empty_pop_rxfe", {31'd0, rxfe}, 32'd1);
        chk("empty_pop_data", rx_data, 32'd0);

        // Frame abort after 3 of 8 bits: nothing pushed, next word intact.
        done_base = done_cnt;
        start_frame(1'b0, 1'b0, 5'd7);
        send_word(32'h5, 3, 1'b0, 1'b0);
        end_frame();
        chk("abort_done", done_cnt - done_base, 32'd0);
        chk("abort_rxfe", {31'd0, rxfe}, 32'd1);
        chk("abort_level", {27'd0, rx_level}, 32'd0);
        start_frame(1'b0, 1'b0, 5'd7);
        send_word(32'h3C, 8, 1'b0, 1'b0);
        end_frame();
        chk("after_abort_data", rx_data, 32'h3C);
        chk("after_abort_level", {27'd0, rx_level}, 32'd1);

        // Reset asserted in the middle of a frame.
        start_frame(1'b0, 1'b0, 5'd7);
        send_word(32'hA, 4, 1'b0, 1'b0);
        reset_n = 1'b0;
        frame_active = 1'b0;
        tick(1);
        chk("rst_mid_rxfe", {31'd0, rxfe}, 32'd1);
        chk("rst_mid_data", rx_data, 32'd0);
        chk("rst_mid_level", {27'd0, rx_level}, 32'd0);
        chk("rst_mid_rxff", {31'd0, rxff}, 32'd0);
        chk("rst_mid_rxfo", {31'd0, rxfo}, 32'd0);
        chk("rst_mid_done", {31'd0, word_done}, 32'd0);
        reset_n = 1'b1;
        tick(3);
        chk("rst_after_rxfe", {31'd0, rxfe}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
